// File: rtl/button_debouncer.sv
// Five-channel push-button conditioner: two-flop synchronizer plus counter debouncer per
// button, producing debounced levels and a one-cycle pulse on each debounced press.

module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic press_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             commit;

    assign differs    = (sync2 != level);
    assign commit     = differs && (cnt == CNT_MAX);
    // Only a debounced rising edge pulses; a debounced release just updates the level.
    assign press_next = commit && sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= press_next;
            if (!differs) begin
                cnt <= '0;
            end else if (commit) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] BtnRaw,
    output logic [4:0] BtnLevel,
    output logic [4:0] BtnPress,
    output logic       AnyPress
);

    logic [4:0] press_next;

    for (genvar i = 0; i < 5; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk       (Clk),
            .rst       (Reset),
            .raw       (BtnRaw[i]),
            .level     (BtnLevel[i]),
            .press     (BtnPress[i]),
            .press_next(press_next[i])
        );
    end

    // Registered from the same next-state bits so it lines up with BtnPress.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            AnyPress <= 1'b0;
        end else begin
            AnyPress <= |press_next;
        end
    end

endmodule
